// File: rtl/clint_smp_if.sv
// MMIO request/response bundle between the memory controller and the CLINT.
interface clint_smp_if;
  logic        w_req_valid;
  logic        w_req_we;
  logic [15:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;

  modport master (
    output w_req_valid, w_req_we, w_req_addr, w_req_wdata,
    input  r_resp_valid, r_resp_rdata
  );

  modport slave (
    input  w_req_valid, w_req_we, w_req_addr, w_req_wdata,
    output r_resp_valid, r_resp_rdata
  );
endinterface

// File: rtl/clint_smp.sv
// Core-local interruptor: free-running mtime, per-hart mtimecmp/msip, registered
// timer-interrupt compare and a single-cycle MMIO register file.
module clint_smp #(
  parameter int N_HARTS  = 2,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  clint_smp_if.slave         mmio,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);

  // Prescaler runs as a down-counter: a tick happens when it hits zero, which
  // is TICK_DIV edges after reset or after any mtime write.
  localparam logic [15:0] PRESC_LOAD = 16'(TICK_DIV - 1);

  localparam logic [13:0] WORD_MTIME_LO = 14'h2FFE;
  localparam logic [13:0] WORD_MTIME_HI = 14'h2FFF;

  logic [15:0]        presc;
  logic [63:0]        mtimecmp [N_HARTS];
  logic [13:0]        word;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        rd_data;
  logic [N_HARTS-1:0] msip_we;
  logic [N_HARTS-1:0] cmp_lo_we;
  logic [N_HARTS-1:0] cmp_hi_we;
  logic               time_lo_we;
  logic               time_hi_we;
  logic               unused_addr_bits;

  assign word             = mmio.w_req_addr[15:2];
  assign wr_en            = mmio.w_req_valid & mmio.w_req_we;
  assign rd_en            = mmio.w_req_valid & ~mmio.w_req_we;
  assign unused_addr_bits = ^mmio.w_req_addr[1:0];

  always_comb begin
    rd_data    = '0;
    msip_we    = '0;
    cmp_lo_we  = '0;
    cmp_hi_we  = '0;
    time_lo_we = 1'b0;
    time_hi_we = 1'b0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (word == 14'(h)) begin
        rd_data    = {31'b0, w_msip[h]};
        msip_we[h] = wr_en;
      end
      if (word == 14'(16'h1000 + 2 * h)) begin
        rd_data      = mtimecmp[h][31:0];
        cmp_lo_we[h] = wr_en;
      end
      if (word == 14'(16'h1001 + 2 * h)) begin
        rd_data      = mtimecmp[h][63:32];
        cmp_hi_we[h] = wr_en;
      end
    end
    if (word == WORD_MTIME_LO) begin
      rd_data    = w_mtime[31:0];
      time_lo_we = wr_en;
    end
    if (word == WORD_MTIME_HI) begin
      rd_data    = w_mtime[63:32];
      time_hi_we = wr_en;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc             <= PRESC_LOAD;
      w_mtime           <= '0;
      w_mtip            <= '0;
      w_msip            <= '0;
      mmio.r_resp_valid <= 1'b0;
      mmio.r_resp_rdata <= '0;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp[h] <= '1;
      end
    end else begin
      // Compare uses pre-edge mtime/mtimecmp, so any change shows one cycle later.
      for (int h = 0; h < N_HARTS; h++) begin
        w_mtip[h] <= (w_mtime >= mtimecmp[h]);
        if (msip_we[h])   w_msip[h]          <= mmio.w_req_wdata[0];
        if (cmp_lo_we[h]) mtimecmp[h][31:0]  <= mmio.w_req_wdata;
        if (cmp_hi_we[h]) mtimecmp[h][63:32] <= mmio.w_req_wdata;
      end

      // A software write to mtime wins over the tick and restarts the prescaler.
      if (time_lo_we || time_hi_we) begin
        presc <= PRESC_LOAD;
        w_mtime <= {time_hi_we ? mmio.w_req_wdata : w_mtime[63:32],
                    time_lo_we ? mmio.w_req_wdata : w_mtime[31:0]};
      end else if (presc == 16'd0) begin
        presc   <= PRESC_LOAD;
        w_mtime <= w_mtime + 64'd1;
      end else begin
        presc <= presc - 16'd1;
      end

      mmio.r_resp_valid <= rd_en;
      if (rd_en) begin
        mmio.r_resp_rdata <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_clint_smp.sv
// Bench for clint_smp: two instances (TICK_DIV=1 and 4) share one MMIO stimulus
// stream and are checked every cycle against a behavioural register model.
module tb_clint_smp;

  localparam int NH = 2;
  localparam int TD [2] = '{1, 4};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic [63:0]   mtime_o [2];
  logic [NH-1:0] mtip_o  [2];
  logic [NH-1:0] msip_o  [2];
  logic          resp_v  [2];
  logic [31:0]   resp_d  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  clint_smp_if bus_a ();
  clint_smp_if bus_b ();

  assign bus_a.w_req_valid = req_valid;
  assign bus_a.w_req_we    = req_we;
  assign bus_a.w_req_addr  = req_addr;
  assign bus_a.w_req_wdata = req_wdata;
  assign bus_b.w_req_valid = req_valid;
  assign bus_b.w_req_we    = req_we;
  assign bus_b.w_req_addr  = req_addr;
  assign bus_b.w_req_wdata = req_wdata;
  assign resp_v[0] = bus_a.r_resp_valid;
  assign resp_d[0] = bus_a.r_resp_rdata;
  assign resp_v[1] = bus_b.r_resp_valid;
  assign resp_d[1] = bus_b.r_resp_rdata;

  clint_smp #(.N_HARTS(NH), .TICK_DIV(1)) dut_a (
    .CLK(CLK), .RST(RST), .mmio(bus_a),
    .w_mtime(mtime_o[0]), .w_mtip(mtip_o[0]), .w_msip(msip_o[0])
  );

  clint_smp #(.N_HARTS(NH), .TICK_DIV(4)) dut_b (
    .CLK(CLK), .RST(RST), .mmio(bus_b),
    .w_mtime(mtime_o[1]), .w_mtip(mtip_o[1]), .w_msip(msip_o[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mtime as an integer plus a cycles-since-tick count.
  logic [63:0]   m_time [2];
  int            m_pre  [2];
  logic [63:0]   m_cmp  [2][NH];
  logic [NH-1:0] m_msip [2];
  logic [NH-1:0] m_mtip [2];
  logic          m_rv   [2];
  logic [31:0]   m_rd   [2];
  bit            m_ok = 1'b0;

  function automatic logic [31:0] m_read(input int i, input logic [15:0] a);
    int w;
    int h;
    w = int'(a[15:2]);
    if (w < NH) return {31'b0, m_msip[i][w]};
    if (w >= 'h1000 && w < 'h1000 + 2 * NH) begin
      h = (w - 'h1000) / 2;
      return (w % 2 == 1) ? m_cmp[i][h][63:32] : m_cmp[i][h][31:0];
    end
    if (w == 'h2FFE) return m_time[i][31:0];
    if (w == 'h2FFF) return m_time[i][63:32];
    return 32'h0;
  endfunction

  initial forever begin
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        m_time[i] = '0;
        m_pre[i]  = 0;
        m_msip[i] = '0;
        m_mtip[i] = '0;
        m_rv[i]   = 1'b0;
        m_rd[i]   = '0;
        for (int h = 0; h < NH; h++) m_cmp[i][h] = '1;
        m_ok = 1'b1;
      end else begin
        automatic bit tick = 1'b1;
        automatic int w = int'(req_addr[15:2]);
        for (int h = 0; h < NH; h++) m_mtip[i][h] = (m_time[i] >= m_cmp[i][h]);
        if (req_valid && !req_we) begin
          m_rv[i] = 1'b1;
          m_rd[i] = m_read(i, req_addr);
        end else begin
          m_rv[i] = 1'b0;
        end
        if (req_valid && req_we) begin
          if (w < NH) begin
            m_msip[i][w] = req_wdata[0];
          end else if (w >= 'h1000 && w < 'h1000 + 2 * NH) begin
            if (w % 2 == 1) m_cmp[i][(w - 'h1000) / 2][63:32] = req_wdata;
            else            m_cmp[i][(w - 'h1000) / 2][31:0]  = req_wdata;
          end else if (w == 'h2FFE) begin
            m_time[i][31:0] = req_wdata;
            m_pre[i] = 0;
            tick = 1'b0;
          end else if (w == 'h2FFF) begin
            m_time[i][63:32] = req_wdata;
            m_pre[i] = 0;
            tick = 1'b0;
          end
        end
        if (tick) begin
          if (m_pre[i] == TD[i] - 1) begin
            m_time[i] = m_time[i] + 64'd1;
            m_pre[i]  = 0;
          end else begin
            m_pre[i]++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (m_ok) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mtime[%0d]", i), mtime_o[i], m_time[i]);
        chk($sformatf("mtip[%0d]", i), 64'(mtip_o[i]), 64'(m_mtip[i]));
        chk($sformatf("msip[%0d]", i), 64'(msip_o[i]), 64'(m_msip[i]));
        chk($sformatf("resp_valid[%0d]", i), 64'(resp_v[i]), 64'(m_rv[i]));
        chk($sformatf("resp_rdata[%0d]", i), 64'(resp_d[i]), 64'(m_rd[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    cyc();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    // Reset state and first read
    do_reset();
    chk("rst_mtime", mtime_o[0], 64'd0);
    chk("rst_mtip", 64'(mtip_o[0]), 64'd0);
    chk("rst_msip", 64'(msip_o[0]), 64'd0);
    chk("rst_resp_valid", 64'(resp_v[0]), 64'd0);
    rd(16'h4004);
    chk("rst_cmp_hi_valid", 64'(resp_v[0]), 64'd1);
    chk("rst_cmp_hi_data", 64'(resp_d[0]), 64'hFFFF_FFFF);
    cyc();
    chk("rst_resp_pulse", 64'(resp_v[0]), 64'd0);

    // Timer fire on hart 0 (TICK_DIV=1 instance)
    do_reset();
    wr(16'h4000, 32'd10);
    wr(16'h4004, 32'd0);
    for (int n = 0; n < 50 && mtime_o[0] != 64'd10; n++) cyc();
    chk("fire_mtime_reached", mtime_o[0], 64'd10);
    chk("fire_mtip_before", 64'(mtip_o[0]), 64'd0);
    cyc();
    chk("fire_mtip_rise", 64'(mtip_o[0]), 64'b01);
    wr(16'h4000, 32'hFFFF_FFFF);
    chk("fire_mtip_hold", 64'(mtip_o[0]), 64'b01);
    cyc();
    chk("fire_mtip_fall", 64'(mtip_o[0]), 64'd0);

    // Prescaler and low-to-high carry
    do_reset();
    repeat (40) cyc();
    chk("presc_b_40", mtime_o[1], 64'd10);
    chk("presc_a_40", mtime_o[0], 64'd40);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    chk("presc_b_wr", mtime_o[1], 64'hFFFF_FFFF);
    repeat (4) cyc();
    chk("presc_b_carry", mtime_o[1], 64'h1_0000_0000);
    chk("presc_a_carry", mtime_o[0], 64'h1_0000_0003);

    // Software interrupt
    wr(16'h0004, 32'hFFFF_FFFF);
    chk("msip_set", 64'(msip_o[0]), 64'b10);
    rd(16'h0004);
    chk("msip_read", 64'(resp_d[0]), 64'd1);
    wr(16'h0004, 32'd0);
    chk("msip_clr", 64'(msip_o[0]), 64'd0);

    // Unmapped and out-of-range hart accesses
    wr(16'h0008, 32'd1);
    wr(16'h4010, 32'd5);
    chk("oob_msip", 64'(msip_o[0]), 64'd0);
    rd(16'h2000);
    chk("oob_rd_valid", 64'(resp_v[0]), 64'd1);
    chk("oob_rd_data", 64'(resp_d[0]), 64'd0);
    cyc();
    chk("oob_rd_pulse", 64'(resp_v[0]), 64'd0);
    rd(16'h4010);
    chk("oob_cmp2_data", 64'(resp_d[0]), 64'd0);
    rd(16'h4000);
    chk("cmp0_lo_data", 64'(resp_d[0]), 64'hFFFF_FFFF);
    rd(16'h400C);
    chk("cmp1_hi_data", 64'(resp_d[0]), 64'hFFFF_FFFF);

    // mtime write colliding with the increment, then back-to-back reads
    do_reset();
    wr(16'hBFF8, 32'd100);
    chk("coll_wr", mtime_o[0], 64'd100);
    cyc();
    chk("coll_next", mtime_o[0], 64'd101);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'hBFF8;
    cyc();
    chk("b2b_rd0", 64'(resp_d[0]), 64'd101);
    cyc();
    req_valid = 1'b0;
    chk("b2b_valid1", 64'(resp_v[0]), 64'd1);
    chk("b2b_rd1", 64'(resp_d[0]), 64'd102);

    // Reset with a read in flight drops the response
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h4004;
    RST       = 1'b1;
    cyc();
    chk("rst_drop_valid", 64'(resp_v[0]), 64'd0);
    chk("rst_drop_data", 64'(resp_d[0]), 64'd0);
    req_valid = 1'b0;
    RST       = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
